lfsr_galois_checker: RTL and testbench

Serial pseudo-random bit-stream checker, the receive-side companion of the team's Galois LFSR pattern generator. It consumes one bit per enabled cycle and self-synchronises to the stream using only the programmed polynomial; no seed is needed. Once locked, it flags every bit that violates the LFSR recurrence and keeps saturating error and bit counters. It sits at the far end of a BIST/link-test path, after the serialiser or channel under test.

---
 rtl/lfsr_galois_checker.sv | 152 +++++++++++++++
 tb/tb_lfsr_galois_checker.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_galois_checker.sv
// Self-synchronising checker for a Galois LFSR bit stream.
// Locks on the tap recurrence and counts mismatches once locked.
module lfsr_galois_checker #(
  parameter int MAX_LEN  = 8,
  parameter int LOCK_THR = 16,
  parameter int LOSS_THR = 8,
  parameter int CNT_W    = 16
) (
  input  logic               CLK_I,
  input  logic               RST_N_I,
  input  logic               LOAD_I,
  input  logic [MAX_LEN-1:0] POLY_I,
  input  logic               EN_I,
  input  logic               DATA_I,
  output logic               LOCKED_O,
  output logic               ERR_O,
  output logic [CNT_W-1:0]   ERR_CNT_O,
  output logic [CNT_W-1:0]   BIT_CNT_O
);

  localparam int FW = $clog2(MAX_LEN + 1);
  localparam int MW = $clog2(LOCK_THR + 1);
  localparam int BW = $clog2(LOSS_THR + 2) + 1;

  localparam logic [FW-1:0] FILL_LAST  = FW'(MAX_LEN - 1);
  localparam logic [MW-1:0] MATCH_LAST = MW'(LOCK_THR - 1);
  localparam logic [BW-1:0] LOSS_LVL   = BW'(LOSS_THR);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FILL,
    S_HUNT,
    S_LOCKED
  } state_t;

  state_t             state_q, state_d;
  logic [MAX_LEN-1:0] poly_q, poly_d;
  logic [MAX_LEN-1:0] hist_q, hist_d;
  logic [FW-1:0]      fill_q, fill_d;
  logic [MW-1:0]      match_q, match_d;
  logic [BW-1:0]      bucket_q, bucket_d;
  logic [BW-1:0]      bucket_sum;
  logic [CNT_W-1:0]   err_cnt_q, err_cnt_d;
  logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic               err_q, err_d;
  logic               locked_q, locked_d;
  logic               pred;
  logic               bad;

  // An all-zero history predicts zero forever, so it never counts as lock evidence
  assign pred       = ^(poly_q & hist_q);
  assign bad        = (DATA_I != pred) || (hist_q == '0);
  assign bucket_sum = bucket_q + BW'(2);

  always_comb begin
    state_d   = state_q;
    poly_d    = poly_q;
    hist_d    = hist_q;
    fill_d    = fill_q;
    match_d   = match_q;
    bucket_d  = bucket_q;
    err_cnt_d = err_cnt_q;
    bit_cnt_d = bit_cnt_q;
    err_d     = 1'b0;
    if (LOAD_I) begin
      poly_d    = POLY_I;
      hist_d    = '0;
      fill_d    = '0;
      match_d   = '0;
      bucket_d  = '0;
      err_cnt_d = '0;
      bit_cnt_d = '0;
      state_d   = (POLY_I != '0) ? S_FILL : S_IDLE;
    end else if (EN_I && state_q != S_IDLE) begin
      hist_d = {hist_q[MAX_LEN-2:0], DATA_I};
      unique case (state_q)
        S_FILL: begin
          if (fill_q == FILL_LAST) begin
            state_d = S_HUNT;
            fill_d  = '0;
            match_d = '0;
          end else begin
            fill_d = fill_q + 1'b1;
          end
        end
        S_HUNT: begin
          if (bad) begin
            match_d = '0;
          end else if (match_q == MATCH_LAST) begin
            state_d  = S_LOCKED;
            match_d  = '0;
            bucket_d = '0;
          end else begin
            match_d = match_q + 1'b1;
          end
        end
        S_LOCKED: begin
          if (bit_cnt_q != {CNT_W{1'b1}})
            bit_cnt_d = bit_cnt_q + 1'b1;
          if (bad) begin
            err_d = 1'b1;
            if (err_cnt_q != {CNT_W{1'b1}})
              err_cnt_d = err_cnt_q + 1'b1;
            if (bucket_sum >= LOSS_LVL) begin
              state_d  = S_HUNT;
              match_d  = '0;
              bucket_d = '0;
            end else begin
              bucket_d = bucket_sum;
            end
          end else if (bucket_q != '0) begin
            bucket_d = bucket_q - 1'b1;
          end
        end
        default: ;
      endcase
    end
    locked_d = (state_d == S_LOCKED);
  end

  always_ff @(posedge CLK_I or negedge RST_N_I) begin
    if (!RST_N_I) begin
      state_q   <= S_IDLE;
      poly_q    <= '0;
      hist_q    <= '0;
      fill_q    <= '0;
      match_q   <= '0;
      bucket_q  <= '0;
      err_cnt_q <= '0;
      bit_cnt_q <= '0;
      err_q     <= 1'b0;
      locked_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      poly_q    <= poly_d;
      hist_q    <= hist_d;
      fill_q    <= fill_d;
      match_q   <= match_d;
      bucket_q  <= bucket_d;
      err_cnt_q <= err_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      err_q     <= err_d;
      locked_q  <= locked_d;
    end
  end

  assign LOCKED_O  = locked_q;
  assign ERR_O     = err_q;
  assign ERR_CNT_O = err_cnt_q;
  assign BIT_CNT_O = bit_cnt_q;

endmodule

// File: tb/tb_lfsr_galois_checker.sv
// Bench for lfsr_galois_checker: reference model, vector table
// and directed lock/error/saturation/reset sequences.
module tb_lfsr_galois_checker;

  localparam logic [7:0] POLY = 8'hB8;
  localparam int M_IDLE = 0;
  localparam int M_FILL = 1;
  localparam int M_HUNT = 2;
  localparam int M_LOCK = 3;

  logic clk = 1'b0;
  logic rst_n;
  logic load;
  logic [7:0] poly;
  logic en;
  logic data;
  logic lk16, err16;
  logic [15:0] ec16, bc16;
  logic lk4, err4;
  logic [3:0] ec4, bc4;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  lfsr_galois_checker #(.MAX_LEN(8), .LOCK_THR(16), .LOSS_THR(8), .CNT_W(16)) dut (
    .CLK_I(clk), .RST_N_I(rst_n), .LOAD_I(load), .POLY_I(poly),
    .EN_I(en), .DATA_I(data), .LOCKED_O(lk16), .ERR_O(err16),
    .ERR_CNT_O(ec16), .BIT_CNT_O(bc16)
  );

  lfsr_galois_checker #(.MAX_LEN(8), .LOCK_THR(16), .LOSS_THR(8), .CNT_W(4)) dut4 (
    .CLK_I(clk), .RST_N_I(rst_n), .LOAD_I(load), .POLY_I(poly),
    .EN_I(en), .DATA_I(data), .LOCKED_O(lk4), .ERR_O(err4),
    .ERR_CNT_O(ec4), .BIT_CNT_O(bc4)
  );

  // reference model: recurrence over a history array, integer counters
  int m_mode, m_fill, m_match, m_bucket, m_errc, m_bitc;
  bit m_err;
  bit [7:0] m_poly;
  bit m_hist[8];
  bit [7:0] gen_s;

  function automatic int sat(int v, int mx);
    return (v > mx) ? mx : v;
  endfunction

  function automatic void model_reset();
    m_mode = M_IDLE; m_fill = 0; m_match = 0; m_bucket = 0;
    m_errc = 0; m_bitc = 0; m_err = 0; m_poly = 0;
    for (int i = 0; i < 8; i++) m_hist[i] = 0;
  endfunction

  function automatic void model_step(bit ld, bit [7:0] p, bit e, bit d);
    bit pr, hz, bd;
    m_err = 0;
    if (ld) begin
      model_reset();
      m_poly = p;
      m_mode = (p != 0) ? M_FILL : M_IDLE;
      return;
    end
    if (!e || m_mode == M_IDLE) return;
    pr = 0; hz = 1;
    for (int i = 0; i < 8; i++) begin
      if (m_poly[i]) pr ^= m_hist[i];
      if (m_hist[i]) hz = 0;
    end
    bd = (d != pr) || hz;
    for (int i = 7; i > 0; i--) m_hist[i] = m_hist[i-1];
    m_hist[0] = d;
    case (m_mode)
      M_FILL: begin
        m_fill++;
        if (m_fill == 8) begin m_mode = M_HUNT; m_match = 0; end
      end
      M_HUNT: begin
        m_match = bd ? 0 : m_match + 1;
        if (m_match == 16) begin m_mode = M_LOCK; m_bucket = 0; end
      end
      M_LOCK: begin
        m_bitc++;
        if (bd) begin
          m_err = 1; m_errc++; m_bucket += 2;
          if (m_bucket >= 8) begin m_mode = M_HUNT; m_match = 0; end
        end else if (m_bucket > 0) begin
          m_bucket--;
        end
      end
      default: ;
    endcase
  endfunction

  function automatic bit gen_next();
    bit b;
    b = gen_s[0];
    gen_s = (gen_s >> 1) ^ (b ? POLY : 8'h00);
    return b;
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  task automatic check_all();
    bit lk;
    lk = (m_mode == M_LOCK);
    chk("model16", 64'({lk16, err16, ec16, bc16}),
        64'({lk, m_err, 16'(sat(m_errc, 65535)), 16'(sat(m_bitc, 65535))}));
    chk("model4", 64'({lk4, err4, ec4, bc4}),
        64'({lk, m_err, 4'(sat(m_errc, 15)), 4'(sat(m_bitc, 15))}));
  endtask

  task automatic drive(bit ld, bit [7:0] p, bit e, bit d);
    load = ld; poly = p; en = e; data = d;
    @(posedge clk);
    model_step(ld, p, e, d);
    #1;
    check_all();
  endtask

  typedef struct {
    bit ld; bit [7:0] p; bit e; bit d;
    bit lk; bit er; int ec; int bc;
  } vec_t;

  vec_t tbl[6];
  bit seen, prev_en;
  int cnt, valid, exp_ec;

  initial begin
    tbl[0] = '{1, 8'h00, 1, 1, 0, 0, 0, 0};
    tbl[1] = '{0, 8'h00, 1, 1, 0, 0, 0, 0};
    tbl[2] = '{0, 8'h00, 1, 0, 0, 0, 0, 0};
    tbl[3] = '{1, POLY,  1, 1, 0, 0, 0, 0};
    tbl[4] = '{0, 8'h00, 0, 1, 0, 0, 0, 0};
    tbl[5] = '{1, 8'h00, 0, 0, 0, 0, 0, 0};

    rst_n = 0; load = 0; poly = 0; en = 0; data = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset16", 64'({lk16, err16, ec16, bc16}), 64'(0));
    chk("reset4", 64'({lk4, err4, ec4, bc4}), 64'(0));
    rst_n = 1;

    for (int i = 0; i < 6; i++) begin
      drive(tbl[i].ld, tbl[i].p, tbl[i].e, tbl[i].d);
      chk($sformatf("vec%0d", i), 64'({lk16, err16, ec16, bc16}),
          64'({tbl[i].lk, tbl[i].er, 16'(tbl[i].ec), 16'(tbl[i].bc)}));
    end

    // clean stream: lock after exactly 24 bits, then 1000 clean bits
    gen_s = 8'h01;
    drive(1, POLY, 0, 0);
    for (int k = 1; k <= 24; k++) begin
      drive(0, 0, 1, gen_next());
      if (k == 23) chk("lock_early", 64'(lk16), 64'(0));
      if (k == 24) chk("lock_at24", 64'(lk16), 64'(1));
    end
    for (int k = 0; k < 1000; k++) drive(0, 0, 1, gen_next());
    chk("clean_err", 64'(ec16), 64'(0));
    chk("clean_bits", 64'(bc16), 64'(1000));

    // single inverted bit
    cnt = 0;
    seen = 0;
    for (int k = 0; k < 9; k++) begin
      drive(0, 0, 1, gen_next() ^ (k == 0));
      if (err16) cnt++;
      if (!lk16) seen = 1;
    end
    chk("flip_pulses", 64'(cnt), 64'(5));
    chk("flip_errcnt", 64'(ec16), 64'(5));
    chk("flip_unlock", 64'(seen), 64'(0));
    for (int k = 0; k < 20; k++) drive(0, 0, 1, gen_next());

    // 20 bits of noise (first 4 forced wrong) then relock
    seen = 0;
    for (int k = 0; k < 20; k++) begin
      if (k < 4) drive(0, 0, 1, ~gen_next());
      else begin
        void'(gen_next());
        drive(0, 0, 1, 1'($urandom));
      end
      if (!lk16) seen = 1;
    end
    chk("noise_drop", 64'(seen), 64'(1));
    exp_ec = m_errc;
    for (int k = 0; k < 24; k++) drive(0, 0, 1, gen_next());
    chk("relock", 64'(lk16), 64'(1));
    chk("errcnt_held", 64'(ec16), 64'(exp_ec));

    // random enable gaps on a clean stream
    gen_s = 8'h01;
    drive(1, POLY, 0, 0);
    valid = 0;
    prev_en = 0;
    for (int c = 0; c < 400 && valid < 24; c++) begin
      bit e;
      e = 1'($urandom);
      if (e) begin
        drive(0, 0, 1, gen_next());
        valid++;
      end else begin
        drive(0, 0, 0, 1'($urandom));
      end
      if (!prev_en) chk("err_after_idle", 64'(err16), 64'(0));
      prev_en = e;
      if (e && valid == 23) chk("gap_lock_early", 64'(lk16), 64'(0));
    end
    chk("gap_valid", 64'(valid), 64'(24));
    chk("gap_lock", 64'(lk16), 64'(1));

    // all-zero stream never locks
    drive(1, POLY, 0, 0);
    seen = 0;
    for (int k = 0; k < 500; k++) begin
      drive(0, 0, 1, 0);
      if (lk16) seen = 1;
    end
    chk("zero_nolock", 64'(seen), 64'(0));

    // repeated error bursts: 4-bit counter sticks at 15
    gen_s = 8'h01;
    drive(1, POLY, 0, 0);
    for (int k = 0; k < 24; k++) drive(0, 0, 1, gen_next());
    for (int r = 0; r < 5; r++) begin
      for (int k = 0; k < 4; k++) drive(0, 0, 1, ~gen_next());
      for (int k = 0; k < 40 && !lk16; k++) drive(0, 0, 1, gen_next());
      chk($sformatf("burst_relock%0d", r), 64'(lk16), 64'(1));
    end
    chk("sat_err4", 64'(ec4), 64'(15));
    chk("sat_bit4", 64'(bc4), 64'(15));
    chk("wide_err", 64'(ec16 >= 16'd20), 64'(1));

    // asynchronous reset while locked
    #3;
    rst_n = 0;
    #1;
    model_reset();
    chk("arst16", 64'({lk16, err16, ec16, bc16}), 64'(0));
    chk("arst4", 64'({lk4, err4, ec4, bc4}), 64'(0));
    @(negedge clk);
    rst_n = 1;
    for (int k = 0; k < 30; k++) drive(0, 0, 1, gen_next());
    chk("arst_idle", 64'({lk16, ec16, bc16}), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
